// File: rtl/cpu_trace_pkg.sv
// Shared constants and types for the CPU-trace stream arbiter: line delimiters,
// checker format codes, error-bit positions, arbiter state and verdict tag.
package cpu_trace_pkg;

    localparam logic [7:0] CH_START = 8'h5E;  // '^'
    localparam logic [7:0] CH_END   = 8'h23;  // '#'
    localparam logic [7:0] CH_NUL   = 8'h00;

    localparam logic [1:0] FMT_NONE = 2'b00;
    localparam logic [1:0] FMT_REG  = 2'b01;
    localparam logic [1:0] FMT_MEM  = 2'b10;

    localparam int unsigned ERR_TIME_BIT = 0;
    localparam int unsigned ERR_PC_BIT   = 1;
    localparam int unsigned ERR_ADDR_BIT = 2;
    localparam int unsigned ERR_GRF_BIT  = 3;

    // Widest source ID supported (N_SRC up to 8)
    localparam int unsigned SRC_W_MAX = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic                 vld;
        logic                 abort;
        logic [SRC_W_MAX-1:0] src;
    } verdict_tag_t;

    // A malformed line carries no meaningful error code
    function automatic logic [3:0] gate_error(input logic [1:0] fmt, input logic [3:0] err);
        return (fmt == FMT_NONE) ? 4'h0 : err;
    endfunction

endpackage

// File: rtl/trace_stream_arbiter_if.sv
// Stream-source, checker and verdict signals of the trace stream arbiter.
// master = environment (sources + checker), slave = arbiter.
interface trace_stream_arbiter_if #(
    parameter int unsigned N_SRC = 4,
    parameter int unsigned SRC_W = $clog2(N_SRC)
);
    logic [N_SRC-1:0]   src_valid;
    logic [8*N_SRC-1:0] src_char;
    logic [N_SRC-1:0]   src_ready;
    logic [7:0]         chk_char;
    logic [1:0]         chk_format;
    logic [3:0]         chk_error;
    logic               res_valid;
    logic [SRC_W-1:0]   res_src;
    logic [1:0]         res_type;
    logic [3:0]         res_error;
    logic               res_abort;
    logic               busy;

    modport master (
        output src_valid, src_char, chk_format, chk_error,
        input  src_ready, chk_char, res_valid, res_src, res_type, res_error, res_abort, busy
    );

    modport slave (
        input  src_valid, src_char, chk_format, chk_error,
        output src_ready, chk_char, res_valid, res_src, res_type, res_error, res_abort, busy
    );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational N-way round-robin arbiter: the first requester at or after
// i_ptr (wrapping) wins. The pointer itself is kept by the parent.
module rr_arbiter #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_gnt_c,
    output logic [IDX_W-1:0] o_gnt_idx_c,
    output logic             o_gnt_vld_c
);

    always_comb begin : p_rr
        int unsigned idx;
        o_gnt_c     = '0;
        o_gnt_idx_c = '0;
        o_gnt_vld_c = 1'b0;
        idx         = 0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = 32'(i_ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!o_gnt_vld_c && i_req[IDX_W'(idx)]) begin
                o_gnt_vld_c              = 1'b1;
                o_gnt_c[IDX_W'(idx)]     = 1'b1;
                o_gnt_idx_c              = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/trace_stream_arbiter.sv
// Line-granular arbiter sharing one trace line checker between N_SRC character
// streams; returns each checker verdict tagged with its source ID.
module trace_stream_arbiter
    import cpu_trace_pkg::*;
#(
    parameter int unsigned N_SRC    = 4,
    parameter int unsigned MAX_LINE = 64,
    parameter int unsigned SRC_W    = $clog2(N_SRC)
) (
    input  logic                   clk,
    input  logic                   reset,
    trace_stream_arbiter_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(MAX_LINE + 1);

    arb_state_e       r_state, w_state_nxt;
    logic [SRC_W-1:0] r_owner, w_owner_nxt;
    logic [SRC_W-1:0] r_ptr,   w_ptr_nxt;
    logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;
    logic [7:0]       r_chk_char, w_chk_char_nxt;
    verdict_tag_t     r_tag1, r_tag2, w_tag_push;

    logic             r_res_valid;
    logic [SRC_W-1:0] r_res_src;
    logic [1:0]       r_res_type;
    logic [3:0]       r_res_error;
    logic             r_res_abort;

    logic [7:0]       w_char [N_SRC];
    logic [N_SRC-1:0] w_cand;
    logic [N_SRC-1:0] w_gnt;
    logic [SRC_W-1:0] w_gnt_idx;
    logic             w_gnt_vld;
    logic [N_SRC-1:0] w_ready;
    logic             w_own_valid;
    logic [7:0]       w_own_char;

    // Unpack per-source chars; a source competes only when presenting '^'
    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
        assign w_char[gi] = bus.src_char[8*gi +: 8];
        assign w_cand[gi] = bus.src_valid[gi] && (bus.src_char[8*gi +: 8] == CH_START);
    end

    assign w_own_valid = bus.src_valid[r_owner];
    assign w_own_char  = w_char[r_owner];

    rr_arbiter #(
        .N     (N_SRC),
        .IDX_W (SRC_W)
    ) u_rr (
        .i_req       (w_cand),
        .i_ptr       (r_ptr),
        .o_gnt_c     (w_gnt),
        .o_gnt_idx_c (w_gnt_idx),
        .o_gnt_vld_c (w_gnt_vld)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_owner    <= '0;
            r_ptr      <= '0;
            r_cnt      <= '0;
            r_chk_char <= CH_NUL;
        end else begin
            r_state    <= w_state_nxt;
            r_owner    <= w_owner_nxt;
            r_ptr      <= w_ptr_nxt;
            r_cnt      <= w_cnt_nxt;
            r_chk_char <= w_chk_char_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_owner_nxt    = r_owner;
        w_ptr_nxt      = r_ptr;
        w_cnt_nxt      = r_cnt;
        w_chk_char_nxt = CH_NUL;
        w_ready        = '0;
        w_tag_push     = '0;

        unique case (r_state)
            ST_IDLE: begin
                // Non-'^' chars are resync-dropped; losing '^' candidates are held
                w_ready = (bus.src_valid & ~w_cand) | w_gnt;
                if (w_gnt_vld) begin
                    w_chk_char_nxt = w_char[w_gnt_idx];
                    w_owner_nxt    = w_gnt_idx;
                    w_ptr_nxt      = (32'(w_gnt_idx) == N_SRC - 1) ? '0 : w_gnt_idx + SRC_W'(1);
                    w_cnt_nxt      = CNT_W'(1);
                    w_state_nxt    = ST_LOCK;
                end
            end

            ST_LOCK: begin
                if (w_own_valid) begin
                    w_ready[r_owner] = 1'b1;
                    w_chk_char_nxt   = w_own_char;
                    if (w_own_char == CH_END) begin
                        w_state_nxt = ST_IDLE;
                        w_tag_push  = '{vld: 1'b1, abort: 1'b0, src: SRC_W_MAX'(r_owner)};
                    end else if (w_own_char == CH_START) begin
                        w_cnt_nxt = CNT_W'(1);
                    end else if (r_cnt == CNT_W'(MAX_LINE - 1)) begin
                        // Line overran MAX_LINE: this char still goes out, then abort
                        w_state_nxt = ST_IDLE;
                        w_tag_push  = '{vld: 1'b1, abort: 1'b1, src: SRC_W_MAX'(r_owner)};
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_tag_push  = '{vld: 1'b1, abort: 1'b1, src: SRC_W_MAX'(r_owner)};
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Tag pipeline: tag reaches stage 2 when the checker shows that line's verdict
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tag1 <= '0;
            r_tag2 <= '0;
        end else begin
            r_tag1 <= w_tag_push;
            r_tag2 <= r_tag1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_res_valid <= 1'b0;
            r_res_src   <= '0;
            r_res_type  <= FMT_NONE;
            r_res_error <= 4'h0;
            r_res_abort <= 1'b0;
        end else begin
            r_res_valid <= r_tag2.vld;
            r_res_src   <= r_tag2.vld ? SRC_W'(r_tag2.src) : '0;
            r_res_abort <= r_tag2.vld && r_tag2.abort;
            if (r_tag2.vld && !r_tag2.abort) begin
                r_res_type  <= bus.chk_format;
                r_res_error <= gate_error(bus.chk_format, bus.chk_error);
            end else begin
                r_res_type  <= FMT_NONE;
                r_res_error <= 4'h0;
            end
        end
    end

    assign bus.src_ready = reset ? '0 : w_ready;
    assign bus.chk_char  = r_chk_char;
    assign bus.busy      = (r_state == ST_LOCK);
    assign bus.res_valid = r_res_valid;
    assign bus.res_src   = r_res_src;
    assign bus.res_type  = r_res_type;
    assign bus.res_error = r_res_error;
    assign bus.res_abort = r_res_abort;

    a_gnt_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(w_gnt));
    a_lock_single: assert property (@(posedge clk) disable iff (reset)
        (r_state == ST_LOCK) |-> $onehot0(bus.src_ready));
    a_owner_range: assert property (@(posedge clk) disable iff (reset)
        32'(r_owner) < N_SRC);

endmodule

// File: tb/tb_trace_stream_arbiter.sv
// Randomized self-checking bench for trace_stream_arbiter against a per-cycle
// behavioural model built from queues of source chars and a verdict schedule.
module tb_trace_stream_arbiter;
    import cpu_trace_pkg::*;

    localparam int unsigned N     = 4;
    localparam int unsigned MAXL  = 64;
    localparam int          NCYC  = 8192;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    trace_stream_arbiter_if #(.N_SRC(N)) bus ();

    trace_stream_arbiter #(.N_SRC(N), .MAX_LINE(MAXL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    // Source streams and stimulus knobs
    logic [7:0] sq [N][$];
    int         hold [N];
    int         stall_pct;
    bit         rst_now;
    bit         fake_rand;
    logic [1:0] fake_fmt;
    logic [3:0] fake_err;

    // Model state and verdict schedule (indexed by cycle number)
    bit         m_lock;
    int         m_owner, m_ptr, m_cnt;
    logic [7:0] m_chk;
    bit         m_busy;
    int         cyc;
    bit         v_on    [NCYC];
    int         v_src   [NCYC];
    bit         v_abort [NCYC];
    logic [1:0] fmt_log [NCYC];
    logic [3:0] err_log [NCYC];
    int         obs_src [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic push_str(input int s, input string str);
        for (int i = 0; i < str.len(); i++) sq[s].push_back(str[i]);
    endtask

    task automatic push_rand_line(input int s);
        int len;
        int r;
        if ($urandom_range(0, 4) != 0) sq[s].push_back(CH_START);
        len = int'($urandom_range(0, 75));
        for (int i = 0; i < len; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 3)       sq[s].push_back(CH_START);
            else if (r < 8)  sq[s].push_back(CH_END);
            else             sq[s].push_back(8'(8'h30 + r % 10));
        end
        if ($urandom_range(0, 3) != 0) sq[s].push_back(CH_END);
    endtask

    function automatic bit pending();
        for (int i = 0; i < N; i++) if (sq[i].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic close_line(input bit ab);
        m_lock          = 1'b0;
        v_on[cyc+3]     = 1'b1;
        v_src[cyc+3]    = m_owner;
        v_abort[cyc+3]  = ab;
    endtask

    // One clock cycle: check registered outputs, drive inputs, check ready, advance model
    task automatic step();
        logic [N-1:0] vv;
        logic [N-1:0] rdy;
        logic [7:0]   cc [N];
        logic [7:0]   n_chk;
        logic [1:0]   et;
        logic [3:0]   ee;
        int           win;
        int           s;

        @(negedge clk);
        check_eq("chk_char", bus.chk_char, m_chk);
        check_eq("busy", bus.busy, m_busy);
        check_eq("res_valid", bus.res_valid, v_on[cyc]);
        if (v_on[cyc]) begin
            et = v_abort[cyc] ? FMT_NONE : fmt_log[cyc-1];
            ee = (et == FMT_NONE) ? 4'h0 : err_log[cyc-1];
            check_eq("res_src", bus.res_src, v_src[cyc]);
            check_eq("res_type", bus.res_type, et);
            check_eq("res_error", bus.res_error, ee);
            check_eq("res_abort", bus.res_abort, v_abort[cyc]);
        end
        if (bus.res_valid) obs_src.push_back(int'(bus.res_src));

        fmt_log[cyc]   = fake_rand ? 2'($urandom_range(0, 2)) : fake_fmt;
        err_log[cyc]   = fake_rand ? 4'($urandom_range(0, 15)) : fake_err;
        bus.chk_format = fmt_log[cyc];
        bus.chk_error  = err_log[cyc];
        reset          = rst_now;
        for (int i = 0; i < N; i++) begin
            vv[i] = (hold[i] == 0) && (sq[i].size() > 0) && (int'($urandom_range(0, 99)) >= stall_pct);
            if (hold[i] > 0) hold[i]--;
            cc[i] = vv[i] ? sq[i][0] : 8'($urandom_range(0, 255));
            bus.src_char[8*i +: 8] = cc[i];
        end
        bus.src_valid = vv;
        #1;

        rdy   = '0;
        n_chk = CH_NUL;
        if (rst_now) begin
            m_lock = 1'b0;
            m_ptr  = 0;
            m_cnt  = 0;
            for (int d = 1; d <= 3; d++) v_on[cyc+d] = 1'b0;
        end else if (!m_lock) begin
            win = -1;
            for (int k = 0; k < N; k++) begin
                s = (m_ptr + k) % N;
                if (win < 0 && vv[s] && cc[s] == CH_START) win = s;
            end
            for (int i = 0; i < N; i++) rdy[i] = (i == win) || (vv[i] && cc[i] != CH_START);
            if (win >= 0) begin
                n_chk   = cc[win];
                m_lock  = 1'b1;
                m_owner = win;
                m_ptr   = (win + 1) % N;
                m_cnt   = 1;
            end
        end else if (vv[m_owner]) begin
            rdy[m_owner] = 1'b1;
            n_chk        = cc[m_owner];
            if (cc[m_owner] == CH_END) close_line(1'b0);
            else if (cc[m_owner] == CH_START) m_cnt = 1;
            else begin
                m_cnt++;
                if (m_cnt == MAXL) close_line(1'b1);
            end
        end else begin
            close_line(1'b1);
        end
        check_eq("src_ready", bus.src_ready, rdy);
        for (int i = 0; i < N; i++) if (rdy[i]) void'(sq[i].pop_front());
        m_chk  = n_chk;
        m_busy = m_lock;
        cyc++;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((m_lock || pending()) && n < budget) begin
            step();
            n++;
        end
        check_eq("drain_done", !(m_lock || pending()), 1);
        repeat (4) step();
    endtask

    initial begin
        string zeros;
        bus.src_valid  = '0;
        bus.src_char   = '0;
        bus.chk_format = FMT_NONE;
        bus.chk_error  = 4'h0;
        reset     = 1'b1;
        rst_now   = 1'b1;
        fake_rand = 1'b0;
        fake_fmt  = FMT_REG;
        fake_err  = 4'h0;
        stall_pct = 0;
        for (int i = 0; i < N; i++) hold[i] = 0;
        m_lock = 1'b0; m_owner = 0; m_ptr = 0; m_cnt = 0;
        m_chk  = CH_NUL; m_busy = 1'b0; cyc = 0;
        repeat (2) @(posedge clk);

        // Reset state with src0 already presenting '^'
        push_str(0, "^10@00003000: $1 <= 0000000a#");
        step();
        step();
        rst_now = 1'b0;
        drain(200);

        // Register line with time/pc/grf errors from src2
        fake_err = 4'b1011;
        push_str(2, "^7@00003001: $40 <= 00000000#");
        drain(200);

        // All sources contend from reset: grants must rotate 0,1,2,3
        rst_now = 1'b1;
        step();
        rst_now = 1'b0;
        obs_src.delete();
        fake_rand = 1'b1;
        for (int i = 0; i < N; i++) push_str(i, "^1@00003002: $3 <= 00000001#");
        drain(400);
        check_eq("grant_count", obs_src.size(), N);
        for (int k = 0; k < obs_src.size() && k < N; k++) check_eq("grant_order", obs_src[k], k);

        // Owner stalls mid-line; the tail is dropped as garbage
        push_str(1, "^5@00003004: $");
        drain(200);
        push_str(1, "1 <= 00000001#");
        drain(200);

        // Overlong line forces a timeout abort
        zeros = "";
        for (int i = 0; i < 70; i++) zeros = {zeros, "0"};
        push_str(3, {"^", zeros});
        drain(300);

        // Src1 blocked while src0 owns the checker; its leading garbage is dropped
        push_str(0, "^9@00003008: *00000010 <= 00000002#");
        step();
        push_str(1, "xyz^7@0000300c: $2 <= 00000003#");
        drain(300);

        // Reset mid-line discards the line with no verdict
        push_str(2, "^11@00003010: $4 <= 00000004#");
        repeat (6) step();
        rst_now = 1'b1;
        step();
        rst_now = 1'b0;
        drain(200);

        // Randomized traffic with stalls, overruns, garbage and one reset
        stall_pct = 5;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (sq[i].size() < 3 && $urandom_range(0, 9) == 0) push_rand_line(i);
                if ($urandom_range(0, 49) == 0) hold[i] = int'($urandom_range(1, 3));
            end
            rst_now = (c == 1500 || c == 1501);
            step();
        end
        rst_now   = 1'b0;
        stall_pct = 0;
        drain(2000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
        $fatal(1);
    end

endmodule

// File: doc/trace_stream_arbiter.md
Name: trace_stream_arbiter

Overview:
Shares one CPU-trace line checker between N_SRC independent character streams, e.g. several simulated cores or UART taps. Lines have the form "^time@pc: $grf <= data#" or "^time@pc: *addr <= data#".
- Arbitration is line-granular. A source that wins on '^' keeps the checker until '#', a stall, or a timeout.
- Chars from unlocked sources that are not '^' are dropped.
- The checker verdict (format_type, error_code) is returned tagged with the source ID.
- Sits between the stream sources and the checker; the checker's freq input is wired at top level.

Parameters:
N_SRC, 4, number of requesting streams (2..8)
MAX_LINE, 64, max chars forwarded per granted line before forced abort
SRC_W, $clog2(N_SRC), width of source ID fields

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
src_valid  in  N_SRC  stream i presents a char
src_char  in  8*N_SRC  char of stream i, bits [8i+7:8i]
src_ready  out  N_SRC  char of stream i consumed this cycle (combinational)
chk_char  out  8  registered char driven into checker every cycle
chk_format  in  2  checker format_type (00 none, 01 register line, 10 memory line)
chk_error  in  4  checker error_code
res_valid  out  1  one-cycle verdict pulse
res_src  out  SRC_W  source the verdict belongs to
res_type  out  2  captured format (00 = malformed or aborted)
res_error  out  4  captured error code (0 when res_type = 00)
res_abort  out  1  verdict caused by stall or timeout, not '#'
busy  out  1  a line is locked

Behaviour:
- Reset: state IDLE; chk_char = 8'h00; rr pointer = 0; all res_* = 0; busy = 0; src_ready = 0; tag pipeline cleared. Reset mid-line discards the line with no verdict.
- FSM has two states, IDLE and LOCK.
- IDLE, candidates: sources with src_valid and char == '^'.
  - Round-robin among candidates, starting at pointer. Winner gets src_ready = 1 and its char is registered into chk_char.
  - Then: owner <= winner, pointer <= winner+1 mod N_SRC, cnt <= 1, go to LOCK.
  - Losing candidates: src_ready = 0 (held, not dropped).
  - Non-candidate valid sources: src_ready = 1, char discarded (resync drop).
  - With no winner, chk_char <= 8'h00.
- LOCK, forwarding the owner:
  - Owner valid: src_ready[owner] = 1, chk_char <= char, cnt++. All other sources get src_ready = 0.
  - Char '#': go to IDLE and push tag {owner, abort = 0} into the 2-stage verdict pipeline.
  - Char '^': forwarded, cnt <= 1, lock kept (the checker restarts the line).
  - Owner not valid (stall): chk_char <= 8'h00, go to IDLE, push tag {owner, abort = 1}.
  - cnt reaches MAX_LINE without '#': that char is forwarded, then go to IDLE and push tag {owner, abort = 1}. The next cycle drives 8'h00.
- Verdict timing: a '#' accepted in cycle t appears on chk_char in t+1. The checker shows the verdict in t+2, it is registered, and res_valid is high in t+3.
  - Non-abort: res_type/res_error = chk_format/chk_error sampled in t+2.
  - Abort: res_type = 00, res_error = 0, res_abort = 1, also at accept/stall cycle + 3.
- Back-to-back operation: a new grant is allowed in the cycle after '#' is accepted. The pipeline holds up to 2 tags, so no tag is ever lost.
- busy = (state == LOCK).
- Fairness: under continuous '^' from all sources, grants rotate 0,1,2,3,0…

Decomposition:
- Package cpu_trace_pkg:
  - char constants CH_START '^', CH_END '#', CH_NUL 8'h00
  - format codes FMT_NONE/FMT_REG/FMT_MEM
  - error bit positions (time, pc, addr, grf)
  - arbiter state enum
- Sub-module rr_arbiter:
  - N-way round-robin with request vector, pointer, one-hot grant and grant index.
  - Purely combinational; the pointer is held in the parent.

Test Plan:
- Src0 sends "^10@00003000: $1 <= 0000000a#" with freq = 4 -> chars forwarded 1 cycle late; res_valid at '#'-accept + 3, res_src = 0, res_type = 01, res_error = 0000, res_abort = 0.
- Src2 sends "^7@00003001: $40 <= 00000000#" with freq = 4 -> res_type = 01, res_error = 1011 (time, pc, grf bits).
- Src0..3 all present '^' from reset -> grants in order 0,1,2,3, each line completing before the next. Held sources see src_ready = 0 while not owner.
- Src1 locked, drops src_valid for one cycle mid-line -> chk_char = 00 next cycle, busy falls, verdict src = 1, type = 00, abort = 1.
- Src3 sends '^' followed by 70 '0' chars -> 64 chars forwarded, then abort verdict src = 3; remaining chars dropped until the next '^'.
- Src1 sends "xyz^…#" while src0 is locked -> src1 blocked until src0's '#'; after release, 'x','y','z' are dropped (ready = 1, not forwarded) and src1 is granted on '^'. Assert reset mid-line -> no res_valid afterwards, chk_char = 00.
